// File: rtl/nibble_serial_addsub_pkg.sv
// Shared types and constants for the nibble-serial adder/subtractor.
package nibble_serial_addsub_pkg;

    // Width of the shared add/subtract datapath.
    localparam int NIBBLE_W = 4;

    // Sequencer states: waiting for operands, walking nibbles, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_alu.sv
// Combinational 4-bit ripple add/subtract slice.
// Exposes the carry into the top bit so the caller can derive signed overflow.
module nibble_alu
    import nibble_serial_addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                inv,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c3,
    output logic                cout
);

    logic [NIBBLE_W-1:0] bx_s;
    logic [NIBBLE_W:0]   c_s;

    // Optional B inversion followed by a bit-level ripple carry chain.
    always_comb begin
        bx_s   = b ^ {NIBBLE_W{inv}};
        c_s    = '0;
        c_s[0] = cin;
        s      = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]     = a[i] ^ bx_s[i] ^ c_s[i];
            c_s[i+1] = (a[i] & bx_s[i]) | (c_s[i] & (a[i] ^ bx_s[i]));
        end
        c3   = c_s[NIBBLE_W-1];
        cout = c_s[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_addsub.sv
// WIDTH-bit adder/subtractor that reuses one 4-bit slice, LS nibble first.
// Optional feature macro: NIBBLE_SERIAL_ADDSUB_FLAGS_EN enables the signed
// overflow and zero flags; without it both flags are tied low.
module nibble_serial_addsub
    import nibble_serial_addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic [WIDTH-1:0]    a_r;
    logic [WIDTH-1:0]    b_r;
    logic                sub_r;
    logic                carry_r;
    logic [IDX_W-1:0]    idx_r;
    logic [WIDTH-1:0]    sum_r;
    logic                cout_r;

    logic                accept_s;
    logic                last_s;
    logic [NIBBLE_W-1:0] a_nib_s;
    logic [NIBBLE_W-1:0] b_nib_s;
    logic [NIBBLE_W-1:0] nib_s_s;
    logic                nib_c3_s;
    logic                nib_cout_s;
    logic [WIDTH-1:0]    sum_next_s;

    // Handshake signals come only from the state register (and reset for in_ready).
    assign in_ready  = (state_r == IDLE) && !rst;
    assign out_valid = (state_r == DONE);
    assign accept_s  = in_valid && in_ready;
    assign last_s    = (idx_r == LAST_IDX);

    assign out_sum  = sum_r;
    assign out_cout = cout_r;

    // Present the current nibble of each captured operand to the shared slice.
    always_comb begin
        a_nib_s = a_r[int'(idx_r)*NIBBLE_W +: NIBBLE_W];
        b_nib_s = b_r[int'(idx_r)*NIBBLE_W +: NIBBLE_W];
    end

    nibble_alu u_alu (
        .a    (a_nib_s),
        .b    (b_nib_s),
        .inv  (sub_r),
        .cin  (carry_r),
        .s    (nib_s_s),
        .c3   (nib_c3_s),
        .cout (nib_cout_s)
    );

    // Result vector with the current nibble merged in.
    always_comb begin
        sum_next_s = sum_r;
        sum_next_s[int'(idx_r)*NIBBLE_W +: NIBBLE_W] = nib_s_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture, carry chaining and nibble-by-nibble result assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            sub_r   <= 1'b0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            sum_r   <= '0;
            cout_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= in_a;
                        b_r     <= in_b;
                        sub_r   <= in_sub;
                        carry_r <= in_sub;
                        idx_r   <= '0;
                    end
                end
                RUN: begin
                    sum_r   <= sum_next_s;
                    carry_r <= nib_cout_s;
                    idx_r   <= idx_r + IDX_W'(1);
                    if (last_s) begin
                        cout_r <= nib_cout_s;
                    end
                end
                DONE: begin
                    sum_r <= sum_r;
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

`ifdef NIBBLE_SERIAL_ADDSUB_FLAGS_EN
    logic ovf_r;
    logic zero_r;

    // Overflow from the carries around the MSB, zero from the completed sum.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if ((state_r == RUN) && last_s) begin
            ovf_r  <= nib_c3_s ^ nib_cout_s;
            zero_r <= ~|sum_next_s;
        end else begin
            ovf_r  <= ovf_r;
            zero_r <= zero_r;
        end
    end

    assign out_ovf  = ovf_r;
    assign out_zero = zero_r;
`else
    logic unused_c3_s;
    assign unused_c3_s = nib_c3_s;
    assign out_ovf     = 1'b0;
    assign out_zero    = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed, scoreboard-based bench for nibble_serial_addsub (WIDTH=16).
// Expected flags follow NIBBLE_SERIAL_ADDSUB_FLAGS_EN when it is defined.
module tb_nibble_serial_addsub;

    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    exp_t q[$];
    int   n_err = 0;
    int   n_chk = 0;

    nibble_serial_addsub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        logic [W-1:0] bx;
        logic [W:0]   full;
        exp_t         e;
        bx     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, sub};
        e.sum  = full[W-1:0];
        e.cout = full[W];
`ifdef NIBBLE_SERIAL_ADDSUB_FLAGS_EN
        e.ovf  = (a[W-1] == bx[W-1]) && (e.sum[W-1] != a[W-1]);
        e.zero = (e.sum == '0);
`else
        e.ovf  = 1'b0;
        e.zero = 1'b0;
`endif
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation: accept, measure latency, optionally stall, then drain.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                          input int hold, input bit junk);
        exp_t e;
        int   lat;
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        check("ready_before_accept", {31'd0, in_ready}, 32'd1);
        q.push_back(model(a, b, sub));
        tick();
        if (junk) begin
            in_a   = 16'hDEAD;
            in_b   = 16'hBEEF;
            in_sub = ~sub;
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            check("ready_low_run", {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        check("latency", lat, N);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_sum", {16'd0, out_sum}, {16'd0, q[0].sum});
            check("hold_cout", {31'd0, out_cout}, {31'd0, q[0].cout});
            tick();
        end
        out_ready = 1'b1;
        if (q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check("valid", {31'd0, out_valid}, 32'd1);
            check("sum", {16'd0, out_sum}, {16'd0, e.sum});
            check("cout", {31'd0, out_cout}, {31'd0, e.cout});
            check("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
            check("zero", {31'd0, out_zero}, {31'd0, e.zero});
        end
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("valid_after_hs", {31'd0, out_valid}, 32'd0);
        check("ready_after_hs", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, out_sum}, 32'd0);
        check("rst_flags", {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
        rst = 1'b0;
        #1;
        check("ready_after_rst", {31'd0, in_ready}, 32'd1);

        run_op(16'h1234, 16'h0FFF, 1'b0, 0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b1, 0, 1'b0);
        run_op(16'h0007, 16'h0005, 1'b1, 0, 1'b0);
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
        run_op(16'hA5C3, 16'h5A3C, 1'b0, 5, 1'b1);
        run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);

        // Reset during the second RUN cycle discards the operation.
        in_a     = 16'h1111;
        in_b     = 16'h2222;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("ready_during_rst", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("abort_sum", {16'd0, out_sum}, 32'd0);
        check("abort_flags", {29'd0, out_cout, out_ovf, out_zero}, 32'd0);
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end

        run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0);
        check("scoreboard_empty", q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
